// File: rtl/bcd_chain_counter.sv
// rtl/bcd_chain_counter.sv - cascaded BCD up/down counter with clear, load, wrap pulses
module bcd_chain_counter #(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 6000
) (
    input  logic                  clk100hz,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        int          r;
        logic [W-1:0] res;
        r   = v;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r             = r / 10;
        end
        return res;
    endfunction

    // Top of the count range in BCD; with valid digits, BCD vectors order like their decimal values.
    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         carry_q, carry_d;
    logic         borrow_q, borrow_d;
    logic         lerr_q, lerr_d;

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         load_ok;

    always_comb begin
        logic c;
        inc_val = cnt_q;
        c       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    c                 = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic b;
        dec_val = cnt_q;
        b       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    b                 = 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic digits_ok;
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
        load_ok = digits_ok && (load_val <= MAX_BCD);
    end

    // Priority: clr over load over en; lower requests in the same cycle are dropped.
    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        lerr_d   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            if (load_ok) begin
                cnt_d = load_val;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (cnt_q == MAX_BCD) begin
                    cnt_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    cnt_d = inc_val;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d    = MAX_BCD;
                    borrow_d = 1'b1;
                end else begin
                    cnt_d = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            lerr_q   <= lerr_d;
        end
    end

    assign cnt        = cnt_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign load_err   = lerr_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// tb/tb_bcd_chain_counter.sv - directed self-checking bench for bcd_chain_counter
module tb_bcd_chain_counter;

    logic        clk100hz;
    logic        rst;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] cnt;
    logic        carry_out;
    logic        borrow_out;
    logic        load_err;

    int total;
    int bad;

    bcd_chain_counter #(.DIGITS(4), .MODULUS(6000)) dut (
        .clk100hz   (clk100hz),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .cnt        (cnt),
        .carry_out  (carry_out),
        .borrow_out (borrow_out),
        .load_err   (load_err)
    );

    initial clk100hz = 1'b0;
    always #5 clk100hz = ~clk100hz;

    task automatic tick();
        @(posedge clk100hz);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;
    endtask

    task automatic do_load(input logic [15:0] v);
        idle();
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #3;
        total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL reset_cnt: got %h want 0000", cnt); end
        total++; if ({carry_out, borrow_out, load_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {carry_out, borrow_out, load_err}); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_carry_wrap();
        do_load(16'h5998);
        total++; if (cnt !== 16'h5998) begin bad++; $display("FAIL cw_load: got %h want 5998", cnt); end
        en = 1'b1; up = 1'b1;
        tick();
        total++; if (cnt !== 16'h5999 || carry_out !== 1'b0) begin bad++; $display("FAIL cw_step1: got %h/%b want 5999/0", cnt, carry_out); end
        tick();
        total++; if (cnt !== 16'h0000 || carry_out !== 1'b1) begin bad++; $display("FAIL cw_wrap: got %h/%b want 0000/1", cnt, carry_out); end
        tick();
        total++; if (cnt !== 16'h0001 || carry_out !== 1'b0) begin bad++; $display("FAIL cw_after: got %h/%b want 0001/0", cnt, carry_out); end
        idle();
    endtask

    task automatic test_borrow_wrap();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (cnt !== 16'h0000 || borrow_out !== 1'b0) begin bad++; $display("FAIL bw_clr: got %h/%b want 0000/0", cnt, borrow_out); end
        en = 1'b1; up = 1'b0;
        tick();
        total++; if (cnt !== 16'h5999 || borrow_out !== 1'b1) begin bad++; $display("FAIL bw_wrap: got %h/%b want 5999/1", cnt, borrow_out); end
        tick();
        total++; if (cnt !== 16'h5998 || borrow_out !== 1'b0) begin bad++; $display("FAIL bw_after: got %h/%b want 5998/0", cnt, borrow_out); end
        idle();
    endtask

    task automatic test_load_err();
        do_load(16'h1234);
        total++; if (cnt !== 16'h1234 || load_err !== 1'b0) begin bad++; $display("FAIL le_base: got %h/%b want 1234/0", cnt, load_err); end
        do_load(16'h0A00);
        total++; if (cnt !== 16'h1234 || load_err !== 1'b1) begin bad++; $display("FAIL le_digit: got %h/%b want 1234/1", cnt, load_err); end
        tick();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL le_digit_clear: got %b want 0", load_err); end
        do_load(16'h6000);
        total++; if (cnt !== 16'h1234 || load_err !== 1'b1) begin bad++; $display("FAIL le_range: got %h/%b want 1234/1", cnt, load_err); end
        tick();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL le_range_clear: got %b want 0", load_err); end
        do_load(16'h5999);
        total++; if (cnt !== 16'h5999 || load_err !== 1'b0) begin bad++; $display("FAIL le_max_ok: got %h/%b want 5999/0", cnt, load_err); end
    endtask

    task automatic test_priority();
        do_load(16'h1234);
        clr = 1'b1; load = 1'b1; load_val = 16'h4321; en = 1'b1; up = 1'b1;
        tick();
        total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL pr_clr_cnt: got %h want 0000", cnt); end
        total++; if ({carry_out, borrow_out, load_err} !== 3'b000) begin bad++; $display("FAIL pr_clr_pulses: got %b want 000", {carry_out, borrow_out, load_err}); end
        clr = 1'b0; load = 1'b1; load_val = 16'h0050;
        tick();
        total++; if (cnt !== 16'h0050) begin bad++; $display("FAIL pr_load_over_en: got %h want 0050", cnt); end
        do_load(16'h5999);
        clr = 1'b1; en = 1'b1; up = 1'b1;
        tick();
        total++; if (cnt !== 16'h0000 || carry_out !== 1'b0) begin bad++; $display("FAIL pr_clr_at_max: got %h/%b want 0000/0", cnt, carry_out); end
        idle();
    endtask

    task automatic test_direction();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0100; exp_seq[1] = 16'h0101; exp_seq[2] = 16'h0100; exp_seq[3] = 16'h0099;
        do_load(16'h0099);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i < 2);
            tick();
            total++; if (cnt !== exp_seq[i]) begin bad++; $display("FAIL dir_step%0d: got %h want %h", i, cnt, exp_seq[i]); end
        end
        en = 1'b0; up = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (cnt !== 16'h0099 || {carry_out, borrow_out, load_err} !== 3'b000) begin bad++; $display("FAIL dir_hold%0d: got %h/%b want 0099/000", i, cnt, {carry_out, borrow_out, load_err}); end
        end
        do_load(16'h0999);
        en = 1'b1; up = 1'b1;
        tick();
        total++; if (cnt !== 16'h1000) begin bad++; $display("FAIL dir_ripple: got %h want 1000", cnt); end
        idle();
    endtask

    task automatic test_async_reset();
        do_load(16'h5999);
        en = 1'b1; up = 1'b1;
        tick();
        total++; if (cnt !== 16'h0000 || carry_out !== 1'b1) begin bad++; $display("FAIL ar_carry: got %h/%b want 0000/1", cnt, carry_out); end
        up = 1'b0;
        tick();
        total++; if (cnt !== 16'h5999 || borrow_out !== 1'b1) begin bad++; $display("FAIL ar_borrow: got %h/%b want 5999/1", cnt, borrow_out); end
        #1 rst = 1'b0;
        #1;
        total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL ar_cnt: got %h want 0000", cnt); end
        total++; if ({carry_out, borrow_out, load_err} !== 3'b000) begin bad++; $display("FAIL ar_pulses: got %b want 000", {carry_out, borrow_out, load_err}); end
        load = 1'b1; load_val = 16'h1234; en = 1'b1;
        tick();
        total++; if (cnt !== 16'h0000) begin bad++; $display("FAIL ar_ignore: got %h want 0000", cnt); end
        idle();
        #2 rst = 1'b1;
        en = 1'b1; up = 1'b0;
        tick();
        total++; if (cnt !== 16'h5999 || borrow_out !== 1'b1) begin bad++; $display("FAIL ar_first_edge: got %h/%b want 5999/1", cnt, borrow_out); end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_carry_wrap();
        test_borrow_wrap();
        test_load_err();
        test_priority();
        test_direction();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_chain_counter.md
BCD_CHAIN_COUNTER -- requirements
Module: bcd_chain_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 SHALL provide parameter MODULUS, default 6000: count range is 0..MODULUS-1 in decimal, legal range 2..10^DIGITS.
REQ-003 SHALL provide port clk100hz, input, 1 bit: clock; all state changes occur on its rising edge, except reset.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL provide port en, input, 1 bit: count enable.
REQ-006 SHALL provide port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-007 SHALL provide port clr, input, 1 bit: synchronous clear to zero.
REQ-008 SHALL provide port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL provide port load_val, input, 4*DIGITS bits: BCD value to load; digit 0 (LSD) is in bits [3:0].
REQ-010 SHALL provide port cnt, output, 4*DIGITS bits: registered BCD count value, same digit order as load_val.
REQ-011 SHALL provide port carry_out, output, 1 bit: registered one-cycle pulse on an up-wrap.
REQ-012 SHALL provide port borrow_out, output, 1 bit: registered one-cycle pulse on a down-wrap.
REQ-013 SHALL provide port load_err, output, 1 bit: registered one-cycle pulse when a load is rejected.

Function
REQ-014 SHALL use this per-edge priority: clr, then load, then en; lower-priority requests in the same cycle SHALL be ignored.
REQ-015 clr=1 SHALL set cnt to 0 and SHALL NOT pulse carry_out or borrow_out.
REQ-016 load=1 with every digit <=9 and value <=MODULUS-1 SHALL set cnt to load_val on that edge.
REQ-017 load=1 with any digit >9 or value >=MODULUS SHALL leave cnt unchanged and SHALL assert load_err for the next cycle.
REQ-018 en=1 with up=1 SHALL increment by 1 in decimal, rippling carries across digits in the same cycle (e.g. 0199 -> 0200).
REQ-019 en=1 with up=0 SHALL decrement by 1 in decimal, rippling borrows across digits in the same cycle (e.g. 0200 -> 0199).
REQ-020 An increment from MODULUS-1 SHALL wrap to 0 and SHALL assert carry_out for exactly the following cycle.
REQ-021 A decrement from 0 SHALL wrap to MODULUS-1 and SHALL assert borrow_out for exactly the following cycle.
REQ-022 carry_out, borrow_out and load_err SHALL deassert on the next edge whatever the state of en, and SHALL never stay high two consecutive cycles unless a second qualifying event occurs.
REQ-023 en=0 with no clr or load SHALL hold cnt unchanged and drive all pulse outputs to 0.
REQ-024 cnt SHALL never hold a non-BCD digit or a value >=MODULUS after reset.
REQ-025 Latency SHALL be 1 cycle: cnt and the pulse outputs reflect an edge's request immediately after that edge.
REQ-026 A change of up between cycles SHALL take effect on the next enabled edge, with no extra step and no skipped step.

Reset
REQ-027 rst=0 SHALL immediately force cnt=0, carry_out=0, borrow_out=0 and load_err=0, independent of clk100hz.
REQ-028 While rst=0, all other inputs SHALL be ignored.
REQ-029 The first counting edge after rst releases SHALL behave as from cnt=0; reset asserted mid-count SHALL discard any pending pulse.

Verification (DIGITS=4, MODULUS=6000)
REQ-030 Load 5998, then en=1, up=1 for 3 edges -> cnt goes 5999, 0000, 0001; carry_out=1 only in the cycle cnt=0000.
REQ-031 clr, then en=1, up=0 for 2 edges -> cnt goes 5999, 5998; borrow_out=1 only in the cycle cnt=5999.
REQ-032 Load 0x0A00 and then 0x6000, each with the previous value at 1234 -> cnt stays 1234; load_err pulses 1 cycle after each.
REQ-033 clr=1, load=1 (load_val 0x4321) and en=1 on the same edge -> cnt=0000 and no pulses.
REQ-034 Count up from 0099 to 0101, toggle up=0 -> cnt steps 0100, 0101, then 0100, 0099; holds 0099 when en=0.
REQ-035 Drop rst low between edges at cnt=5999 after carry -> cnt=0000 and all pulse outputs 0 before the next edge.
